// File: rtl/sram_arbiter_if.sv
// Bundle of the two client ports (A = image loader, B = convolution filter)
// and the registered single-port SRAM interface served by sram_arbiter.
interface sram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              a_req;
  logic              a_we;
  logic              a_lock;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic              b_lock;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              sram_en;
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q;

  // Arbiter side.
  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output sram_en, sram_wen, sram_addr, sram_d,
    input  sram_q
  );

  // Client/SRAM side.
  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  sram_en, sram_wen, sram_addr, sram_d,
    output sram_q
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of one synchronous SRAM: combinational grant with
// alternating priority and optional lock, registered SRAM command, 2-cycle read return.
module sram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_arbiter_if.slave bus
);

  typedef enum logic {PRIO_A, PRIO_B} prio_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;

  prio_e  prio_q, prio_d;
  owner_e owner_q, owner_d;

  logic a_gnt, b_gnt;
  logic hold_a, hold_b;

  logic              sram_en_q, sram_en_d;
  logic              sram_wen_q, sram_wen_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_d_q, sram_d_d;

  // Read tags, bit 0 = port A, bit 1 = port B: stage 1 tracks the SRAM command
  // cycle, stage 2 the cycle sram_q carries the data.
  logic [1:0] rd1_q, rd1_d;
  logic [1:0] rd2_q;

  // Ownership only blocks the other port while the owner keeps its lock high;
  // the cycle the lock drops arbitrates normally.
  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    hold_a = (owner_q == OWN_A) && bus.a_lock;
    hold_b = (owner_q == OWN_B) && bus.b_lock;
    a_gnt  = 1'b0;
    b_gnt  = 1'b0;
    if (hold_a) begin
      a_gnt = bus.a_req;
    end else if (hold_b) begin
      b_gnt = bus.b_req;
    end else if (bus.a_req && bus.b_req) begin
      a_gnt = (prio_q == PRIO_A);
      b_gnt = (prio_q == PRIO_B);
    end else begin
      a_gnt = bus.a_req;
      b_gnt = bus.b_req;
    end
  end

  always_comb begin
    prio_d      = prio_q;
    owner_d     = OWN_NONE;
    sram_en_d   = a_gnt | b_gnt;
    sram_wen_d  = 1'b0;
    sram_addr_d = sram_addr_q;
    sram_d_d    = sram_d_q;
    rd1_d       = 2'b00;
    if (a_gnt) begin
      if (bus.a_lock) owner_d = OWN_A;
      else            prio_d  = PRIO_B;
      sram_wen_d  = bus.a_we;
      sram_addr_d = bus.a_addr;
      sram_d_d    = bus.a_wdata;
      rd1_d[0]    = ~bus.a_we;
    end else if (b_gnt) begin
      if (bus.b_lock) owner_d = OWN_B;
      else            prio_d  = PRIO_A;
      sram_wen_d  = bus.b_we;
      sram_addr_d = bus.b_addr;
      sram_d_d    = bus.b_wdata;
      rd1_d[1]    = ~bus.b_we;
    end
    // An owner idling with its lock still high keeps ownership.
    if (hold_a) owner_d = OWN_A;
    if (hold_b) owner_d = OWN_B;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= PRIO_A;
      owner_q     <= OWN_NONE;
      sram_en_q   <= 1'b0;
      sram_wen_q  <= 1'b0;
      sram_addr_q <= '0;
      sram_d_q    <= '0;
      rd1_q       <= 2'b00;
      rd2_q       <= 2'b00;
    end else begin
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      sram_en_q   <= sram_en_d;
      sram_wen_q  <= sram_wen_d;
      sram_addr_q <= sram_addr_d;
      sram_d_q    <= sram_d_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd1_q;
    end
  end

  assign bus.a_gnt     = a_gnt;
  assign bus.b_gnt     = b_gnt;
  assign bus.sram_en   = sram_en_q;
  assign bus.sram_wen  = sram_wen_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.sram_d    = sram_d_q;
  assign bus.a_rvalid  = rd2_q[0];
  assign bus.b_rvalid  = rd2_q[1];

  // NOTE: read data is not registered; gating sram_q with the tag gives zero
  // rdata in reset and idle cycles without extra flops.
  assign bus.a_rdata = rd2_q[0] ? bus.sram_q : '0;
  assign bus.b_rdata = rd2_q[1] ? bus.sram_q : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural synchronous SRAM.
module tb_sram_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [7:0] mem [0:65535];

  sram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  sram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: write or read on the edge that samples sram_en.
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_wen) mem[bus.sram_addr] <= bus.sram_d;
      else              bus.sram_q <= mem[bus.sram_addr];
    end
  end

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input logic lock,
                         input logic [15:0] addr, input logic [7:0] wdata);
    bus.a_req   = req;
    bus.a_we    = we;
    bus.a_lock  = lock;
    bus.a_addr  = addr;
    bus.a_wdata = wdata;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic lock,
                         input logic [15:0] addr, input logic [7:0] wdata);
    bus.b_req   = req;
    bus.b_we    = we;
    bus.b_lock  = lock;
    bus.b_addr  = addr;
    bus.b_wdata = wdata;
  endtask

  task automatic idle();
    drive_a(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive_b(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_check();
    @(negedge clk);
  endtask

  initial begin
    int j;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [15:0] addr_v;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle();
    for (int i = 0; i < 16'hFFFF; i++) mem[i] = pat(16'(i));
    mem[16'hFFFF] = pat(16'hFFFF);

    // Reset state
    to_drive();
    to_check();
    check("rst_sram_en", bus.sram_en, 1'b0);
    check("rst_sram_wen", bus.sram_wen, 1'b0);
    check("rst_sram_addr", bus.sram_addr, 16'h0000);
    check("rst_sram_d", bus.sram_d, 8'h00);
    check("rst_a_rvalid", bus.a_rvalid, 1'b0);
    check("rst_b_rvalid", bus.b_rvalid, 1'b0);
    check("rst_a_rdata", bus.a_rdata, 8'h00);
    rst_n = 1'b1;

    // A writes 0x5A to 0x0010, then B reads it back
    to_drive();
    drive_a(1'b1, 1'b1, 1'b0, 16'h0010, 8'h5A);
    to_check();
    check("wr_a_gnt", bus.a_gnt, 1'b1);
    check("wr_b_gnt", bus.b_gnt, 1'b0);
    to_drive();
    idle();
    drive_b(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
    to_check();
    check("rd_b_gnt", bus.b_gnt, 1'b1);
    check("rd_a_gnt", bus.a_gnt, 1'b0);
    check("wr_sram_en", bus.sram_en, 1'b1);
    check("wr_sram_wen", bus.sram_wen, 1'b1);
    check("wr_sram_addr", bus.sram_addr, 16'h0010);
    check("wr_sram_d", bus.sram_d, 8'h5A);
    to_drive();
    idle();
    to_check();
    check("rd_sram_en", bus.sram_en, 1'b1);
    check("rd_sram_wen", bus.sram_wen, 1'b0);
    check("rd_b_rvalid_early", bus.b_rvalid, 1'b0);
    to_drive();
    to_check();
    check("rd_b_rvalid", bus.b_rvalid, 1'b1);
    check("rd_b_rdata", bus.b_rdata, 8'h5A);
    check("rd_a_rvalid", bus.a_rvalid, 1'b0);
    check("rd_sram_idle", bus.sram_en, 1'b0);
    to_drive();
    to_check();
    check("rd_b_rvalid_once", bus.b_rvalid, 1'b0);
    check("rd_b_rdata_zero", bus.b_rdata, 8'h00);

    // Both ports reading every cycle: grants alternate starting with A
    for (int k = 0; k < 8; k++) begin
      to_drive();
      if (k < 6) begin
        drive_a(1'b1, 1'b0, 1'b0, 16'(32'h20 + k), 8'h00);
        drive_b(1'b1, 1'b0, 1'b0, 16'(32'h30 + k), 8'h00);
      end else begin
        idle();
      end
      to_check();
      j = k - 2;
      check("alt_a_gnt", bus.a_gnt, (k < 6) && (k % 2 == 0));
      check("alt_b_gnt", bus.b_gnt, (k < 6) && (k % 2 == 1));
      check("alt_a_rvalid", bus.a_rvalid, (j >= 0) && (j % 2 == 0));
      check("alt_b_rvalid", bus.b_rvalid, (j >= 0) && (j % 2 == 1));
      exp_a = ((j >= 0) && (j % 2 == 0)) ? pat(16'(32'h20 + j)) : 8'h00;
      exp_b = ((j >= 0) && (j % 2 == 1)) ? pat(16'(32'h30 + j)) : 8'h00;
      check("alt_a_rdata", bus.a_rdata, exp_a);
      check("alt_b_rdata", bus.b_rdata, exp_b);
    end

    // A locked for 4 cycles against a waiting B; lock drops with both requesting
    for (int k = 0; k < 8; k++) begin
      to_drive();
      if (k < 6) begin
        drive_a(1'b1, 1'b0, k < 4, 16'h0040, 8'h00);
        drive_b(1'b1, 1'b0, 1'b0, 16'h0050, 8'h00);
      end else begin
        idle();
      end
      to_check();
      check("lock_a_gnt", bus.a_gnt, k <= 4);
      check("lock_b_gnt", bus.b_gnt, k == 5);
      check("lock_a_rvalid", bus.a_rvalid, (k >= 2) && (k <= 6));
      check("lock_b_rvalid", bus.b_rvalid, k == 7);
      check("lock_b_rdata", bus.b_rdata, (k == 7) ? pat(16'h0050) : 8'h00);
    end

    // Owner idles with lock high: SRAM idle and B still waits
    to_drive();
    drive_a(1'b1, 1'b0, 1'b1, 16'h0060, 8'h00);
    drive_b(1'b1, 1'b0, 1'b0, 16'h0070, 8'h00);
    to_check();
    check("own_a_gnt", bus.a_gnt, 1'b1);
    to_drive();
    drive_a(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00);
    to_check();
    check("own_idle_b_gnt", bus.b_gnt, 1'b0);
    check("own_idle_a_gnt", bus.a_gnt, 1'b0);
    to_drive();
    drive_a(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    to_check();
    check("own_release_b_gnt", bus.b_gnt, 1'b1);
    check("own_idle_sram_en", bus.sram_en, 1'b0);
    check("own_a_rvalid", bus.a_rvalid, 1'b1);
    check("own_a_rdata", bus.a_rdata, pat(16'h0060));
    to_drive();
    idle();
    to_check();
    check("own_b_sram_addr", bus.sram_addr, 16'h0070);
    to_drive();
    to_check();
    check("own_b_rvalid", bus.b_rvalid, 1'b1);
    check("own_b_rdata", bus.b_rdata, pat(16'h0070));

    // B burst of 16 sequential reads with A idle
    for (int k = 0; k < 18; k++) begin
      to_drive();
      if (k < 16) drive_b(1'b1, 1'b0, 1'b0, 16'(32'h100 + k), 8'h00);
      else        idle();
      to_check();
      addr_v = 16'(32'h100 + k - 2);
      check("burst_b_gnt", bus.b_gnt, k < 16);
      check("burst_a_gnt", bus.a_gnt, 1'b0);
      check("burst_b_rvalid", bus.b_rvalid, k >= 2);
      check("burst_b_rdata", bus.b_rdata, (k >= 2) ? pat(addr_v) : 8'h00);
    end

    // Reset while a read is in flight
    to_drive();
    drive_a(1'b1, 1'b0, 1'b0, 16'h0020, 8'h00);
    to_check();
    check("rstf_a_gnt", bus.a_gnt, 1'b1);
    to_drive();
    idle();
    to_check();
    check("rstf_sram_en_pre", bus.sram_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rstf_sram_en_async", bus.sram_en, 1'b0);
    check("rstf_sram_addr_async", bus.sram_addr, 16'h0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    to_check();
    check("rstf_no_rvalid", bus.a_rvalid, 1'b0);
    to_drive();
    to_check();
    check("rstf_no_rvalid_late", bus.a_rvalid, 1'b0);
    to_drive();
    drive_a(1'b1, 1'b0, 1'b0, 16'h0021, 8'h00);
    drive_b(1'b1, 1'b0, 1'b0, 16'h0031, 8'h00);
    to_check();
    check("rstf_prio_a_gnt", bus.a_gnt, 1'b1);
    check("rstf_prio_b_gnt", bus.b_gnt, 1'b0);
    to_drive();
    to_check();
    check("rstf_next_b_gnt", bus.b_gnt, 1'b1);
    to_drive();
    idle();
    to_drive();

    // No requests: everything quiet
    for (int k = 0; k < 4; k++) begin
      to_drive();
      to_check();
      check("quiet_sram_en", bus.sram_en, 1'b0);
      check("quiet_gnt", {bus.a_gnt, bus.b_gnt}, 2'b00);
      check("quiet_rvalid", {bus.a_rvalid, bus.b_rvalid}, 2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SRAM address width.
REQ-002 Parameter DATA_W, default 8, SRAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 a_req  input  1  port A (image loader) access request.
REQ-006 a_we  input  1  port A: 1 = write, 0 = read.
REQ-007 a_lock  input  1  port A holds ownership while high.
REQ-008 a_addr  input  ADDR_W  port A address.
REQ-009 a_wdata  input  DATA_W  port A write data.
REQ-010 a_gnt  output  1  port A request accepted this cycle.
REQ-011 a_rvalid  output  1  port A read data valid.
REQ-012 a_rdata  output  DATA_W  port A read data.
REQ-013 b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same directions, widths and meanings for port B (convolution filter).
REQ-014 sram_en  output  1  SRAM access enable, registered.
REQ-015 sram_wen  output  1  SRAM write enable (1 = write), registered.
REQ-016 sram_addr  output  ADDR_W  SRAM address, registered.
REQ-017 sram_d  output  DATA_W  SRAM write data, registered.
REQ-018 sram_q  input  DATA_W  SRAM read data, valid the cycle after sram_en is sampled.

Function
REQ-019 Grant shall be combinational: at most one of a_gnt/b_gnt high per cycle; x_gnt high only when x_req high.
REQ-020 Arbitration state: prio (A/B) and owner (NONE/A/B); owner != NONE overrides prio.
REQ-021 owner == NONE, both requesting: grant the port named by prio; one requesting: grant it.
REQ-022 After any unlocked grant, prio shall flip to the other port at the next edge.
REQ-023 Granted port with x_lock high shall set owner = x at next edge; owner remains x while x_lock high.
REQ-024 While owner == x, only x is granted; the other port waits regardless of prio, x idle cycles leave SRAM idle.
REQ-025 owner == x and x_lock low in a cycle shall clear owner to NONE at next edge; arbitration that same cycle follows REQ-021 and prio flips to the other port.
REQ-026 Grant in cycle N shall drive sram_en=1, sram_wen=x_we, sram_addr=x_addr, sram_d=x_wdata in cycle N+1; no grant in N gives sram_en=0, sram_wen=0 in N+1, addr/data held.
REQ-027 Read granted in cycle N: x_rvalid=1 in cycle N+2 for exactly one cycle, x_rdata=sram_q in that cycle; owner tag pipelined two stages.
REQ-028 Writes shall produce no rvalid; x_rdata shall be 0 whenever x_rvalid is 0.
REQ-029 Back-to-back grants (one per cycle) shall be supported; read returns in grant order, no drops.
REQ-030 Read of an address written in the immediately preceding grant shall return the new data (SRAM ordering preserved, no forwarding required).
REQ-031 Request with x_req low for a cycle withdraws it; no queuing inside the block.

Reset
REQ-032 rst_n low shall asynchronously force: prio=A, owner=NONE, sram_en=0, sram_wen=0, sram_addr=0, sram_d=0, a_rvalid=b_rvalid=0, rdata=0, read tag pipeline cleared.
REQ-033 Reads in flight at reset shall be discarded: no rvalid after reset release.
REQ-034 First edge after rst_n rises shall arbitrate normally with prio=A.

Verification
REQ-035 Reset, then a_req=1 a_we=1 addr=0x0010 wdata=0x5A; next cycle b_req=1 b_we=0 addr=0x0010 -> a_gnt cycle 1, b_gnt cycle 2, b_rvalid=1 b_rdata=0x5A cycle 4.
REQ-036 a_req and b_req held high 6 cycles, both reads, no lock -> grants alternate A,B,A,B,A,B; each rvalid two cycles after its grant on correct port.
REQ-037 a_lock=1 with a_req 4 cycles while b_req=1 -> a_gnt 4 consecutive cycles, b_gnt 0; cycle a_lock drops with both requesting, grant A, then B.
REQ-038 Burst B: 16 sequential reads 0x0100..0x010F with A idle -> b_gnt every cycle, 16 rvalid pulses in order, data matching preloaded bytes.
REQ-039 Read granted, rst_n pulsed low one cycle before return -> no rvalid, sram_en=0 immediately, prio=A after release.
REQ-040 No requests -> sram_en=0, both gnt=0, both rvalid=0 every cycle.
